// File: rtl/data_memory_ba.sv
// Byte-addressed DEPTH x 32-bit data memory with lane-merged stores, extended registered loads,
// misalignment flagging and a post-reset clear sweep that keeps the array reset-free.
module data_memory_ba #(
   parameter int DEPTH       = 128,
   parameter int ADDR_WIDTH  = 32,
   parameter bit RESET_CLEAR = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemWrite,
   input  logic                  MemRead,
   input  logic [1:0]            size,
   input  logic                  load_unsigned,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           WriteData,
   output logic [31:0]           ReadData,
   output logic                  read_valid,
   output logic                  misaligned,
   output logic                  busy
);

   localparam int IDX = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX-1:0] LAST_IDX = IDX'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t          state_q;
   logic [IDX-1:0]  clr_idx_q;
   logic            busy_q;
   logic [31:0]     rdata_q;
   logic            rvalid_q;
   logic            mis_q;
   logic [31:0]     mem_q [DEPTH];

   logic [IDX-1:0]  word_idx_s;
   logic [1:0]      off_s;
   logic            mis_s;
   logic            wr_en_s;
   logic [3:0]      be_s;
   logic [31:0]     wdata_s;
   logic            unused_s;

   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
      logic res;
      case (sz)
         2'b00:   res = 1'b0;
         2'b01:   res = off[0];
         2'b10:   res = |off;
         default: res = 1'b1;
      endcase
      return res;
   endfunction

   // Shift the addressed lanes down to bit 0, then sign- or zero-extend.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] sz, input logic uns);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {off, 3'b000};
      case (sz)
         2'b00:   res = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
         2'b01:   res = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         2'b10:   res = word;
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

   assign word_idx_s = address[IDX+1:2];
   assign off_s      = address[1:0];
   assign mis_s      = is_misaligned(size, off_s);
   assign wr_en_s    = (state_q == ST_READY) && MemWrite && !mis_s;
   assign unused_s   = ^{address};

   // Store lane enables and replicated store data.
   always_comb begin
      be_s    = 4'b0000;
      wdata_s = WriteData;
      case (size)
         2'b00: begin
            be_s    = 4'b0001 << off_s;
            wdata_s = {4{WriteData[7:0]}};
         end
         2'b01: begin
            be_s    = 4'b0011 << off_s;
            wdata_s = {2{WriteData[15:0]}};
         end
         2'b10: begin
            be_s    = 4'b1111;
            wdata_s = WriteData;
         end
         default: begin
            be_s    = 4'b0000;
            wdata_s = WriteData;
         end
      endcase
   end

   // Array write port: clear sweep has priority, otherwise lane-merged stores.
   always_ff @(posedge clk) begin
      if (!reset && (state_q == ST_CLEAR)) begin
         mem_q[clr_idx_q] <= 32'h0000_0000;
      end else if (!reset && wr_en_s) begin
         for (int k = 0; k < 4; k++) begin
            if (be_s[k]) begin
               mem_q[word_idx_s][8*k +: 8] <= wdata_s[8*k +: 8];
            end
         end
      end
   end

   // Control FSM with registered load result and strobes; loads see pre-write contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q   <= 32'h0000_0000;
         rvalid_q  <= 1'b0;
         mis_q     <= 1'b0;
         clr_idx_q <= '0;
         if (RESET_CLEAR) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
         end else begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
         end
      end else begin
         case (state_q)
            ST_CLEAR: begin
               rvalid_q  <= 1'b0;
               mis_q     <= 1'b0;
               clr_idx_q <= clr_idx_q + IDX'(1);
               if (clr_idx_q == LAST_IDX) begin
                  state_q <= ST_READY;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= ST_CLEAR;
                  busy_q  <= 1'b1;
               end
            end
            ST_READY: begin
               rvalid_q <= MemRead;
               mis_q    <= (MemRead || MemWrite) && mis_s;
               busy_q   <= 1'b0;
               if (MemRead) begin
                  rdata_q <= mis_s ? 32'h0000_0000
                                   : load_extend(mem_q[word_idx_s], off_s, size, load_unsigned);
               end else begin
                  rdata_q <= rdata_q;
               end
            end
            default: begin
               state_q  <= ST_READY;
               busy_q   <= 1'b0;
               rvalid_q <= 1'b0;
               mis_q    <= 1'b0;
            end
         endcase
      end
   end

   assign ReadData   = rdata_q;
   assign read_valid = rvalid_q;
   assign misaligned = mis_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_data_memory_ba.sv
// Self-checking bench for data_memory_ba against a byte-array reference model.
module tb_data_memory_ba;

   localparam int DEPTH = 128;
   localparam int BYTES = 4 * DEPTH;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [1:0]  size = 2'b10;
   logic        load_unsigned = 1'b0;
   logic [31:0] address = 32'h0;
   logic [31:0] WriteData = 32'h0;
   logic [31:0] ReadData;
   logic        read_valid;
   logic        misaligned;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [7:0] ref_mem [BYTES];

   data_memory_ba #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .RESET_CLEAR(1'b1)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead), .size(size),
      .load_unsigned(load_unsigned), .address(address), .WriteData(WriteData),
      .ReadData(ReadData), .read_valid(read_valid), .misaligned(misaligned), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
      int base, n;
      logic [31:0] v;
      if (m_mis(sz, a)) return 32'h0;
      base = int'(a % BYTES);
      n = 1 << sz;
      v = 32'h0;
      for (int k = 0; k < n; k++) v = v | (32'(ref_mem[base + k]) << (8 * k));
      if (n == 1 && !uns && v[7])  v = v | 32'hFFFF_FF00;
      if (n == 2 && !uns && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
      int base;
      if (m_mis(sz, a)) return;
      base = int'(a % BYTES);
      for (int k = 0; k < (1 << sz); k++) ref_mem[base + k] = wd[8*k +: 8];
   endtask

   task automatic m_clear();
      for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
   endtask

   // One request cycle; outputs are sampled 1 time unit after the capturing edge.
   task automatic op(input logic we, input logic re, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd);
      MemWrite = we; MemRead = re; size = sz; load_unsigned = uns; address = a; WriteData = wd;
      @(posedge clk); #1;
      MemWrite = 1'b0; MemRead = 1'b0;
   endtask

   task automatic test_reset();
      int cnt;
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", ReadData); end
      checks++; if (read_valid !== 1'b0 || misaligned !== 1'b0) begin errors++; $display("FAIL rst_strobes got %b%b exp 00", read_valid, misaligned); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b exp 1", busy); end
      reset = 1'b0;
      m_clear();
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0);
      checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL busy_load_valid got %b exp 0", read_valid); end
      cnt = 1;
      while (busy === 1'b1 && cnt < 1000) begin @(posedge clk); #1; cnt++; end
      checks++; if (cnt != DEPTH) begin errors++; $display("FAIL busy_len got %0d exp %0d", cnt, DEPTH); end
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h000, 32'h0);
      checks++; if (ReadData !== 32'h0 || read_valid !== 1'b1) begin errors++; $display("FAIL clr_load0 got %h/%b exp 0/1", ReadData, read_valid); end
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h1FC, 32'h0);
      checks++; if (ReadData !== 32'h0 || read_valid !== 1'b1) begin errors++; $display("FAIL clr_load1fc got %h/%b exp 0/1", ReadData, read_valid); end
   endtask

   task automatic test_word_alias();
      op(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF); m_store(32'h10, 2'd2, 32'hDEADBEEF);
      checks++; if (read_valid !== 1'b0 || misaligned !== 1'b0) begin errors++; $display("FAIL store_strobes got %b%b exp 00", read_valid, misaligned); end
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0);
      checks++; if (ReadData !== 32'hDEADBEEF || read_valid !== 1'b1) begin errors++; $display("FAIL word_load got %h/%b exp deadbeef/1", ReadData, read_valid); end
      op(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
      checks++; if (ReadData !== 32'hDEADBEEF || read_valid !== 1'b0) begin errors++; $display("FAIL idle_hold got %h/%b exp deadbeef/0", ReadData, read_valid); end
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h210, 32'h0);
      checks++; if (ReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL alias_load got %h exp deadbeef", ReadData); end
   endtask

   task automatic test_byte_half();
      op(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h11223344); m_store(32'h10, 2'd2, 32'h11223344);
      op(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'hFFFFFF80); m_store(32'h13, 2'd0, 32'hFFFFFF80);
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0);
      checks++; if (ReadData !== 32'h80223344) begin errors++; $display("FAIL byte_merge got %h exp 80223344", ReadData); end
      op(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0);
      checks++; if (ReadData !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed got %h exp ffffff80", ReadData); end
      op(1'b0, 1'b1, 2'd0, 1'b1, 32'h13, 32'h0);
      checks++; if (ReadData !== 32'h00000080) begin errors++; $display("FAIL lb_unsigned got %h exp 00000080", ReadData); end
      op(1'b0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h0);
      checks++; if (ReadData !== 32'hFFFF8022) begin errors++; $display("FAIL lh_signed got %h exp ffff8022", ReadData); end
      op(1'b0, 1'b1, 2'd1, 1'b1, 32'h12, 32'h0);
      checks++; if (ReadData !== 32'h00008022) begin errors++; $display("FAIL lh_unsigned got %h exp 00008022", ReadData); end
   endtask

   task automatic test_read_first();
      op(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'hAAAAAAAA); m_store(32'h20, 2'd2, 32'hAAAAAAAA);
      op(1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h55555555); m_store(32'h20, 2'd2, 32'h55555555);
      checks++; if (ReadData !== 32'hAAAAAAAA || read_valid !== 1'b1) begin errors++; $display("FAIL read_first got %h/%b exp aaaaaaaa/1", ReadData, read_valid); end
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
      checks++; if (ReadData !== 32'h55555555) begin errors++; $display("FAIL after_write got %h exp 55555555", ReadData); end
   endtask

   task automatic test_misaligned();
      op(1'b1, 1'b0, 2'd2, 1'b0, 32'h22, 32'hFFFFFFFF);
      checks++; if (misaligned !== 1'b1 || read_valid !== 1'b0) begin errors++; $display("FAIL mis_store_flag got %b/%b exp 1/0", misaligned, read_valid); end
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
      checks++; if (ReadData !== 32'h55555555 || misaligned !== 1'b0) begin errors++; $display("FAIL mis_store_nochange got %h/%b exp 55555555/0", ReadData, misaligned); end
      op(1'b0, 1'b1, 2'd1, 1'b0, 32'h21, 32'h0);
      checks++; if (ReadData !== 32'h0 || read_valid !== 1'b1 || misaligned !== 1'b1) begin errors++; $display("FAIL mis_half_load got %h/%b/%b exp 0/1/1", ReadData, read_valid, misaligned); end
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0);
      op(1'b0, 1'b1, 2'd3, 1'b0, 32'h20, 32'h0);
      checks++; if (misaligned !== 1'b1 || ReadData !== 32'h0 || read_valid !== 1'b1) begin errors++; $display("FAIL size11_load got %b/%h exp 1/0", misaligned, ReadData); end
      op(1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_pulse_width got %b exp 0", misaligned); end
   endtask

   task automatic test_random();
      logic we, re, uns;
      logic [1:0] sz;
      logic [31:0] a, wd, exp_rd;
      logic exp_mis;
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0);
      exp_rd = m_load(32'h0, 2'd2, 1'b0);
      checks++; if (ReadData !== exp_rd) begin errors++; $display("FAIL rnd_seed got %h exp %h", ReadData, exp_rd); end
      for (int i = 0; i < 300; i++) begin
         we  = 1'($urandom_range(0, 1));
         re  = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a   = 32'($urandom_range(0, 63)) + 32'($urandom_range(0, 7)) * 32'(BYTES);
         if ($urandom_range(0, 4) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         wd = $urandom;
         exp_mis = (we || re) && m_mis(sz, a);
         if (re) exp_rd = m_load(a, sz, uns);
         op(we, re, sz, uns, a, wd);
         if (we) m_store(a, sz, wd);
         checks++;
         if (ReadData !== exp_rd || read_valid !== re || misaligned !== exp_mis) begin
            errors++;
            $display("FAIL rnd_%0d got %h/%b/%b exp %h/%b/%b", i, ReadData, read_valid, misaligned, exp_rd, re, exp_mis);
         end
      end
   endtask

   task automatic test_reset_midsweep();
      int cnt;
      op(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h12345678);
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0);
      checks++; if (ReadData !== 32'h12345678) begin errors++; $display("FAIL pre_reset got %h exp 12345678", ReadData); end
      reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (i == 10) op(1'b1, 1'b1, 2'd2, 1'b0, 32'h44, 32'hCAFEF00D);
         else begin @(posedge clk); #1; end
      end
      checks++; if (busy !== 1'b1 || read_valid !== 1'b0 || misaligned !== 1'b0) begin errors++; $display("FAIL mid_sweep got %b/%b/%b exp 1/0/0", busy, read_valid, misaligned); end
      reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
      m_clear();
      cnt = 0;
      while (busy === 1'b1 && cnt < 1000) begin @(posedge clk); #1; cnt++; end
      checks++; if (cnt != DEPTH) begin errors++; $display("FAIL resweep_len got %0d exp %0d", cnt, DEPTH); end
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0);
      checks++; if (ReadData !== 32'h0 || read_valid !== 1'b1) begin errors++; $display("FAIL resweep_40 got %h/%b exp 0/1", ReadData, read_valid); end
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h44, 32'h0);
      checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL busy_store_44 got %h exp 0", ReadData); end
   endtask

   initial begin
      test_reset();
      test_word_alias();
      test_byte_half();
      test_read_first();
      test_misaligned();
      test_random();
      test_reset_midsweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
